note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_pkg.sv | 36 +++
 rtl/melody_rom.sv | 38 +++
 rtl/note_scheduler.sv | 164 ++++++++++++++++
 tb/tb_note_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// note_pkg: shared constants for the note scheduler.
//   - note divider constants, lower octave DO..SI and upper octave DO_H..SI_H;
//     NO (0) is a rest and drives silence
//   - source encoding reported on the src output
//   - scheduler state encoding (plain localparams so legacy code can reuse them)
package note_pkg;

  localparam int unsigned NO   = 0;
  localparam int unsigned DO   = 95420;
  localparam int unsigned RE   = 85034;
  localparam int unsigned MI   = 75757;
  localparam int unsigned FA   = 71633;
  localparam int unsigned SO   = 63775;
  localparam int unsigned LA   = 56818;
  localparam int unsigned SI   = 50607;
  localparam int unsigned DO_H = 47710;
  localparam int unsigned RE_H = 42517;
  localparam int unsigned MI_H = 37879;
  localparam int unsigned FA_H = 35816;
  localparam int unsigned SO_H = 31888;
  localparam int unsigned LA_H = 28409;
  localparam int unsigned SI_H = 25303;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_MELODY = 2'd1,
    SRC_KEY    = 2'd2,
    SRC_SFX    = 2'd3
  } src_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MELODY = 2'd1;
  localparam logic [1:0] ST_KEY    = 2'd2;
  localparam logic [1:0] ST_SFX    = 2'd3;

endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational background-melody table.
// Ports:
//   idx   in   6       melody index
//   note  out  NOTE_W  divider for that index; 0 (rest) beyond MELODY_LEN-1
module melody_rom
  import note_pkg::*;
#(
  parameter int NOTE_W     = 22,
  parameter int MELODY_LEN = 47
) (
  input  logic [5:0]        idx,
  output logic [NOTE_W-1:0] note
);

  int unsigned val;

  always_comb begin
    val = NO;
    case (idx)
      6'd0:  val = DO;   6'd1:  val = DO;   6'd2:  val = SO;   6'd3:  val = SO;
      6'd4:  val = LA;   6'd5:  val = LA;   6'd6:  val = SO;   6'd7:  val = NO;
      6'd8:  val = FA;   6'd9:  val = FA;   6'd10: val = MI;   6'd11: val = MI;
      6'd12: val = RE;   6'd13: val = RE;   6'd14: val = DO;   6'd15: val = NO;
      6'd16: val = SO;   6'd17: val = SO;   6'd18: val = FA;   6'd19: val = FA;
      6'd20: val = MI;   6'd21: val = MI;   6'd22: val = RE;   6'd23: val = NO;
      6'd24: val = SO_H; 6'd25: val = SO_H; 6'd26: val = FA_H; 6'd27: val = FA_H;
      6'd28: val = MI_H; 6'd29: val = MI_H; 6'd30: val = RE_H; 6'd31: val = NO;
      6'd32: val = DO_H; 6'd33: val = DO_H; 6'd34: val = SO;   6'd35: val = SO;
      6'd36: val = LA_H; 6'd37: val = LA_H; 6'd38: val = SI;   6'd39: val = NO;
      6'd40: val = FA;   6'd41: val = FA;   6'd42: val = MI;   6'd43: val = MI;
      6'd44: val = RE;   6'd45: val = RE;   6'd46: val = DO;
      default: val = NO;
    endcase
  end

  assign note = (int'(idx) < MELODY_LEN) ? NOTE_W'(val) : '0;

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: picks the note sent to the speaker each clk_5 tick.
// Priority: sound effect > held key > background melody > silence.
// Ports:
//   clk_5        in   1          note-rate tick clock
//   rst          in   1          async active-high reset
//   play_en      in   1          background melody enable
//   key_valid    in   1          keyboard note held
//   key_note     in   NOTE_W     divider of the held key
//   sfx_req      in   1          sound-effect request, held until acked
//   sfx_note     in   NOTE_W     effect divider, sampled on accept
//   sfx_len      in   SFX_LEN_W  effect length in ticks (0 treated as 1)
//   note_div     out  NOTE_W     registered divider, 0 = silence
//   src          out  2          0 none, 1 melody, 2 key, 3 sfx
//   sfx_ack      out  1          one-tick pulse on effect accept
//   sfx_busy     out  1          effect playing
//   melody_idx   out  6          index of the next melody note
//   melody_done  out  1          melody ran off its end (non-loop build)
// Build option: define NOTE_SCHED_MELODY_LOOP_EN to loop the melody forever
// instead of stopping at the last entry.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | silence
// ST_MELODY | playing melody ROM (or silence once done)
// ST_KEY    | following the held key
// ST_SFX    | playing latched effect until its counter expires
module note_scheduler
  import note_pkg::*;
#(
  parameter int NOTE_W     = 22,
  parameter int MELODY_LEN = 47,
  parameter int SFX_LEN_W  = 4
) (
  input  logic                 clk_5,
  input  logic                 rst,
  input  logic                 play_en,
  input  logic                 key_valid,
  input  logic [NOTE_W-1:0]    key_note,
  input  logic                 sfx_req,
  input  logic [NOTE_W-1:0]    sfx_note,
  input  logic [SFX_LEN_W-1:0] sfx_len,
  output logic [NOTE_W-1:0]    note_div,
  output logic [1:0]           src,
  output logic                 sfx_ack,
  output logic                 sfx_busy,
  output logic [5:0]           melody_idx,
  output logic                 melody_done
);

  localparam logic [5:0] LAST_IDX = 6'(MELODY_LEN - 1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           src_q, src_d;
  logic [NOTE_W-1:0]    note_div_q, note_div_d;
  logic [NOTE_W-1:0]    sfx_note_q, sfx_note_d;
  logic [SFX_LEN_W-1:0] sfx_cnt_q, sfx_cnt_d;
  logic                 sfx_ack_q, sfx_ack_d;
  logic                 sfx_busy_q, sfx_busy_d;
  logic [5:0]           melody_idx_q, melody_idx_d;
  logic                 melody_done_q, melody_done_d;
  logic [NOTE_W-1:0]    rom_note;
  logic                 sfx_stay;
  logic                 sfx_accept;

  melody_rom #(
    .NOTE_W     (NOTE_W),
    .MELODY_LEN (MELODY_LEN)
  ) u_melody_rom (
    .idx  (melody_idx_q),
    .note (rom_note)
  );

  always_comb begin
    state_d       = ST_IDLE;
    src_d         = SRC_NONE;
    note_div_d    = '0;
    sfx_note_d    = sfx_note_q;
    sfx_cnt_d     = sfx_cnt_q;
    sfx_ack_d     = 1'b0;
    melody_idx_d  = melody_idx_q;
    melody_done_d = melody_done_q;

    // Counter holds the ticks still owed including the current one, so the
    // effect is left on the edge where it steps from 1 to 0.
    sfx_stay   = (state_q == ST_SFX) && (sfx_cnt_q > SFX_LEN_W'(1));
    sfx_accept = (state_q != ST_SFX) && sfx_req;

    if (state_q == ST_SFX && sfx_cnt_q != '0) begin
      sfx_cnt_d = sfx_cnt_q - SFX_LEN_W'(1);
    end

    if (sfx_stay) begin
      state_d    = ST_SFX;
      src_d      = SRC_SFX;
      note_div_d = sfx_note_q;
    end else if (sfx_accept) begin
      state_d    = ST_SFX;
      src_d      = SRC_SFX;
      note_div_d = sfx_note;
      sfx_note_d = sfx_note;
      sfx_cnt_d  = (sfx_len == '0) ? SFX_LEN_W'(1) : sfx_len;
      sfx_ack_d  = 1'b1;
    end else if (key_valid) begin
      state_d    = ST_KEY;
      src_d      = SRC_KEY;
      note_div_d = key_note;
    end else if (play_en) begin
      state_d = ST_MELODY;
      src_d   = SRC_MELODY;
      if (!melody_done_q) begin
        note_div_d = rom_note;
        if (melody_idx_q == LAST_IDX) begin
`ifdef NOTE_SCHED_MELODY_LOOP_EN
          melody_idx_d = '0;
`else
          melody_done_d = 1'b1;
`endif
        end else begin
          melody_idx_d = melody_idx_q + 6'd1;
        end
      end
    end

    // Stopping the game rewinds the melody even while it is preempted.
    if (!play_en) begin
      melody_idx_d  = '0;
      melody_done_d = 1'b0;
    end

    sfx_busy_d = (state_d == ST_SFX);
  end

  always_ff @(posedge clk_5 or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_NONE;
      note_div_q    <= '0;
      sfx_note_q    <= '0;
      sfx_cnt_q     <= '0;
      sfx_ack_q     <= 1'b0;
      sfx_busy_q    <= 1'b0;
      melody_idx_q  <= '0;
      melody_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      note_div_q    <= note_div_d;
      sfx_note_q    <= sfx_note_d;
      sfx_cnt_q     <= sfx_cnt_d;
      sfx_ack_q     <= sfx_ack_d;
      sfx_busy_q    <= sfx_busy_d;
      melody_idx_q  <= melody_idx_d;
      melody_done_q <= melody_done_d;
    end
  end

  assign note_div    = note_div_q;
  assign src         = src_q;
  assign sfx_ack     = sfx_ack_q;
  assign sfx_busy    = sfx_busy_q;
  assign melody_idx  = melody_idx_q;
  assign melody_done = melody_done_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed scenarios plus randomized traffic, every tick
// compared against a behavioural reference of the scheduling rules.
module tb_note_scheduler;
  import note_pkg::*;

  localparam int NOTE_W     = 22;
  localparam int MELODY_LEN = 47;
  localparam int SFX_LEN_W  = 4;

  logic                 clk_5 = 1'b0;
  logic                 rst;
  logic                 play_en;
  logic                 key_valid;
  logic [NOTE_W-1:0]    key_note;
  logic                 sfx_req;
  logic [NOTE_W-1:0]    sfx_note;
  logic [SFX_LEN_W-1:0] sfx_len;
  logic [NOTE_W-1:0]    note_div;
  logic [1:0]           src;
  logic                 sfx_ack;
  logic                 sfx_busy;
  logic [5:0]           melody_idx;
  logic                 melody_done;

  note_scheduler #(
    .NOTE_W     (NOTE_W),
    .MELODY_LEN (MELODY_LEN),
    .SFX_LEN_W  (SFX_LEN_W)
  ) dut (
    .clk_5       (clk_5),
    .rst         (rst),
    .play_en     (play_en),
    .key_valid   (key_valid),
    .key_note    (key_note),
    .sfx_req     (sfx_req),
    .sfx_note    (sfx_note),
    .sfx_len     (sfx_len),
    .note_div    (note_div),
    .src         (src),
    .sfx_ack     (sfx_ack),
    .sfx_busy    (sfx_busy),
    .melody_idx  (melody_idx),
    .melody_done (melody_done)
  );

  always #5 clk_5 = ~clk_5;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned rom_ref [MELODY_LEN] = '{
    DO, DO, SO, SO, LA, LA, SO, NO,
    FA, FA, MI, MI, RE, RE, DO, NO,
    SO, SO, FA, FA, MI, MI, RE, NO,
    SO_H, SO_H, FA_H, FA_H, MI_H, MI_H, RE_H, NO,
    DO_H, DO_H, SO, SO, LA_H, LA_H, SI, NO,
    FA, FA, MI, MI, RE, RE, DO};

  // reference state: effect ticks still owed after the current one,
  // position of the next melody note, and whether the melody ran out
  bit          m_in_sfx;
  int          m_left;
  int unsigned m_sfx_note;
  int          m_pos;
  bit          m_done;
  int unsigned e_note;
  int unsigned e_src;
  bit          e_ack;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_sfx = 0; m_left = 0; m_sfx_note = 0;
    m_pos = 0; m_done = 0;
    e_note = 0; e_src = 0; e_ack = 0;
  endtask

  task automatic model_step();
    bit was_sfx;
    if (rst) begin
      model_reset();
      return;
    end
    was_sfx  = m_in_sfx;
    m_in_sfx = 0;
    e_ack    = 0;
    if (was_sfx && m_left > 0) begin
      m_left--;
      m_in_sfx = 1; e_note = m_sfx_note; e_src = 3;
    end else if (!was_sfx && sfx_req) begin
      m_sfx_note = sfx_note;
      m_left     = (sfx_len == 0) ? 0 : int'(sfx_len) - 1;
      m_in_sfx   = 1; e_ack = 1; e_note = sfx_note; e_src = 3;
    end else if (key_valid) begin
      e_note = key_note; e_src = 2;
    end else if (play_en) begin
      e_src = 1;
      if (m_done) e_note = 0;
      else begin
        e_note = rom_ref[m_pos];
        m_pos++;
`ifdef NOTE_SCHED_MELODY_LOOP_EN
        m_pos = m_pos % MELODY_LEN;
`else
        if (m_pos == MELODY_LEN) m_done = 1;
`endif
      end
    end else begin
      e_note = 0; e_src = 0;
    end
    if (!play_en) begin
      m_pos = 0; m_done = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_note_div"}, note_div, e_note);
    check_val({tag, "_src"}, src, e_src);
    check_val({tag, "_ack"}, sfx_ack, e_ack);
    check_val({tag, "_busy"}, sfx_busy, m_in_sfx);
    check_val({tag, "_idx"}, melody_idx, m_done ? MELODY_LEN - 1 : m_pos);
    check_val({tag, "_done"}, melody_done, m_done);
  endtask

  task automatic tick(input string tag);
    @(posedge clk_5);
    model_step();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1; play_en = 0; key_valid = 0; key_note = '0;
    sfx_req = 0; sfx_note = '0; sfx_len = '0;
    model_reset();
    #3;
    compare_all("reset");
    repeat (2) tick("reset_hold");
    rst = 0;

    // melody from the start
    play_en = 1;
    repeat (5) tick("melody");
    check_val("melody_at_5", melody_idx, 5);

    // effect of 3 ticks, then resume at index 5
    sfx_req = 1; sfx_len = 4'd3; sfx_note = 22'd50607;
    tick("sfx3_accept");
    check_val("sfx3_ack_pulse", sfx_ack, 1);
    sfx_req = 0; sfx_note = '0;
    repeat (2) tick("sfx3_play");
    check_val("sfx3_note", note_div, 50607);
    tick("sfx3_exit");
    check_val("sfx3_resume", note_div, LA);
    repeat (2) tick("melody2");

    // effect and key together: effect wins, key follows
    sfx_req = 1; key_valid = 1; key_note = 22'd95420; sfx_len = 4'd2; sfx_note = 22'(SI_H);
    tick("sfxkey_accept");
    sfx_req = 0;
    repeat (4) tick("sfxkey_run");
    check_val("sfxkey_key_src", src, 2);
    check_val("sfxkey_key_note", note_div, 95420);
    key_valid = 0;
    tick("key_release");

    // zero-length effect and a request held across it
    sfx_req = 1; sfx_len = 4'd0; sfx_note = 22'(MI);
    tick("sfx0_accept");
    sfx_note = 22'(FA);
    tick("sfx0_exit");
    check_val("sfx0_no_ack_on_exit", sfx_ack, 0);
    tick("sfx0_reaccept");
    check_val("sfx0_reack", sfx_ack, 1);
    sfx_req = 0;
    repeat (3) tick("sfx0_after");

    // run the melody to its end
    play_en = 0;
    tick("rewind");
    play_en = 1;
    repeat (MELODY_LEN) tick("full_melody");
`ifdef NOTE_SCHED_MELODY_LOOP_EN
    check_val("end_wrap_idx", melody_idx, 0);
`else
    check_val("end_done", melody_done, 1);
    tick("end_silent");
    check_val("end_note_zero", note_div, 0);
`endif
    repeat (3) tick("end_hold");
    play_en = 0;
    tick("end_clear");
    check_val("end_clear_done", melody_done, 0);
    check_val("end_clear_idx", melody_idx, 0);

    // reset in the middle of an effect
    play_en = 1; sfx_req = 1; sfx_len = 4'd8; sfx_note = 22'(RE);
    tick("rst_sfx_accept");
    tick("rst_sfx_play");
    #2 rst = 1;
    #1 model_reset();
    compare_all("rst_mid_sfx");
    sfx_req = 0;
    tick("rst_mid_hold");
    rst = 0;
    repeat (3) tick("rst_after");
    sfx_req = 1;
    tick("rst_rerequest");
    check_val("rst_reack", sfx_ack, 1);
    sfx_req = 0;
    repeat (9) tick("rst_sfx_done");

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      play_en = ($urandom_range(19) != 0);
      if ($urandom_range(7) == 0) key_valid = ~key_valid;
      key_note = 22'($urandom);
      if (sfx_req) begin
        if ($urandom_range(2) == 0) sfx_req = 0;
      end else begin
        sfx_req = ($urandom_range(9) == 0);
      end
      sfx_note = 22'($urandom);
      sfx_len  = 4'($urandom);
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
